// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the pipeline hazard scoreboard: default widths,
// pipeline slot indices and the forwarding-select encoding.
package hazard_scoreboard_pkg;

    localparam int DEF_REG_ADDR_W = 4;
    localparam int DEF_CNT_W      = 16;

    localparam int NUM_SLOTS = 3;
    localparam int SLOT_EX   = 0;
    localparam int SLOT_MA   = 1;
    localparam int SLOT_WB   = 2;

    // Mux select codes used by the forwarding unit that consumes dest_*/wb_en_*.
    typedef enum logic [1:0] {
        FWD_SEL_RF = 2'b00,
        FWD_SEL_WB = 2'b01,
        FWD_SEL_MA = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard_stage_slot.sv
// One pipeline-stage tracking register: holds on freeze, loads the upstream
// slot otherwise; an invalid load becomes an all-zero bubble.
module sb_stage_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         valid_next,
    input  logic [W-1:0] dest_next,
    input  logic         wb_en_next,
    input  logic         mem_read_next,
    output logic         valid,
    output logic [W-1:0] dest,
    output logic         wb_en,
    output logic         mem_read
);

    logic         valid_reg;
    logic [W-1:0] dest_reg;
    logic         wb_en_reg;
    logic         mem_read_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            dest_reg     <= '0;
            wb_en_reg    <= 1'b0;
            mem_read_reg <= 1'b0;
        end else if (!hold) begin
            // Bubbles carry zero fields so downstream flags are valid-qualified.
            valid_reg    <= valid_next;
            dest_reg     <= valid_next ? dest_next : '0;
            wb_en_reg    <= valid_next & wb_en_next;
            mem_read_reg <= valid_next & mem_read_next;
        end
    end

    assign valid    = valid_reg;
    assign dest     = dest_reg;
    assign wb_en    = wb_en_reg;
    assign mem_read = mem_read_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations through EX/MA/WB, raises the ID stall for
// RAW (no forwarding) or load-use (forwarding) hazards, counts stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic                  forward_en,
    input  logic                  freeze,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic [REG_ADDR_W-1:0] dest_ex,
    output logic [REG_ADDR_W-1:0] dest_ma,
    output logic [REG_ADDR_W-1:0] dest_wb,
    output logic                  wb_en_ex,
    output logic                  wb_en_ma,
    output logic                  wb_en_wb,
    output logic                  mem_read_ex,
    output logic [CNT_W-1:0]      stall_cycles
);

    logic [NUM_SLOTS-1:0]  slot_valid;
    logic [NUM_SLOTS-1:0]  slot_wb_en;
    logic [NUM_SLOTS-1:0]  slot_mem_read;
    logic [REG_ADDR_W-1:0] slot_dest [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]  chain_valid;
    logic [NUM_SLOTS-1:0]  chain_wb_en;
    logic [NUM_SLOTS-1:0]  chain_mem_read;
    logic [REG_ADDR_W-1:0] chain_dest [NUM_SLOTS];

    // Only EX and MA can hazard: WB writes the register file in the first half-cycle.
    logic [SLOT_WB-1:0] hit_src1;
    logic [SLOT_WB-1:0] hit_src2;

    logic hazard_raw;
    logic use_hit_ex;
    logic use_hit_ma;
    logic issue_valid;
    logic unused_wb_load;

    logic [CNT_W-1:0] stall_cnt_reg;

    assign issue_valid = id_valid & ~hazard_raw & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi == SLOT_EX) begin : g_from_id
                assign chain_valid[gi]    = issue_valid;
                assign chain_dest[gi]     = id_dest;
                assign chain_wb_en[gi]    = id_wb_en;
                assign chain_mem_read[gi] = id_mem_read;
            end else begin : g_from_prev
                assign chain_valid[gi]    = slot_valid[gi-1];
                assign chain_dest[gi]     = slot_dest[gi-1];
                assign chain_wb_en[gi]    = slot_wb_en[gi-1];
                assign chain_mem_read[gi] = slot_mem_read[gi-1];
            end

            sb_stage_slot #(
                .W (REG_ADDR_W)
            ) u_slot (
                .clk           (clk),
                .rst           (rst),
                .hold          (freeze),
                .valid_next    (chain_valid[gi]),
                .dest_next     (chain_dest[gi]),
                .wb_en_next    (chain_wb_en[gi]),
                .mem_read_next (chain_mem_read[gi]),
                .valid         (slot_valid[gi]),
                .dest          (slot_dest[gi]),
                .wb_en         (slot_wb_en[gi]),
                .mem_read      (slot_mem_read[gi])
            );
        end

        for (gi = 0; gi < SLOT_WB; gi++) begin : g_hit
            assign hit_src1[gi] = slot_valid[gi] & slot_wb_en[gi] & (id_src1 == slot_dest[gi]);
            assign hit_src2[gi] = slot_valid[gi] & slot_wb_en[gi] & (id_src2 == slot_dest[gi]);
        end
    endgenerate

    always_comb begin
        use_hit_ex = (id_use_src1 & hit_src1[SLOT_EX]) | (id_two_src & hit_src2[SLOT_EX]);
        use_hit_ma = (id_use_src1 & hit_src1[SLOT_MA]) | (id_two_src & hit_src2[SLOT_MA]);
        hazard_raw = 1'b0;
        if (forward_en) begin
            // ALU and MA-stage load results are forwarded; only an EX load blocks.
            hazard_raw = id_valid & slot_mem_read[SLOT_EX] & use_hit_ex;
        end else begin
            hazard_raw = id_valid & (use_hit_ex | use_hit_ma);
        end
    end

    // A taken branch kills the ID instruction, so the PC must not be held.
    assign hazard_stall = hazard_raw & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (hazard_stall && !freeze && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign unused_wb_load = slot_mem_read[SLOT_WB];

    assign dest_ex      = slot_dest[SLOT_EX];
    assign dest_ma      = slot_dest[SLOT_MA];
    assign dest_wb      = slot_dest[SLOT_WB];
    assign wb_en_ex     = slot_valid[SLOT_EX] & slot_wb_en[SLOT_EX];
    assign wb_en_ma     = slot_valid[SLOT_MA] & slot_wb_en[SLOT_MA];
    assign wb_en_wb     = slot_valid[SLOT_WB] & slot_wb_en[SLOT_WB];
    assign mem_read_ex  = slot_valid[SLOT_EX] & slot_mem_read[SLOT_EX];
    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, a saturation run on a
// narrow-counter instance, and random traffic against a pipeline model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_use_src1;
    logic       id_two_src;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_read;
    logic       forward_en;
    logic       freeze;
    logic       flush;

    logic        hazard_stall, hazard_stall_s;
    logic [3:0]  dest_ex, dest_ma, dest_wb, dest_ex_s, dest_ma_s, dest_wb_s;
    logic        wb_en_ex, wb_en_ma, wb_en_wb, wb_en_ex_s, wb_en_ma_s, wb_en_wb_s;
    logic        mem_read_ex, mem_read_ex_s;
    logic [15:0] stall_cycles;
    logic [3:0]  stall_cycles_s;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .forward_en(forward_en),
        .freeze(freeze), .flush(flush), .hazard_stall(hazard_stall),
        .dest_ex(dest_ex), .dest_ma(dest_ma), .dest_wb(dest_wb),
        .wb_en_ex(wb_en_ex), .wb_en_ma(wb_en_ma), .wb_en_wb(wb_en_wb),
        .mem_read_ex(mem_read_ex), .stall_cycles(stall_cycles)
    );

    // Narrow counter so saturation is reachable in a short run.
    hazard_scoreboard #(.REG_ADDR_W(4), .CNT_W(4)) u_dut_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .forward_en(forward_en),
        .freeze(freeze), .flush(flush), .hazard_stall(hazard_stall_s),
        .dest_ex(dest_ex_s), .dest_ma(dest_ma_s), .dest_wb(dest_wb_s),
        .wb_en_ex(wb_en_ex_s), .wb_en_ma(wb_en_ma_s), .wb_en_wb(wb_en_wb_s),
        .mem_read_ex(mem_read_ex_s), .stall_cycles(stall_cycles_s)
    );

    // Reference model: list of in-flight instructions, index 0 = EX.
    typedef struct {
        bit       v;
        bit [3:0] d;
        bit       w;
        bit       m;
    } mslot_t;

    mslot_t      ms [3];
    int unsigned m_cnt;

    function automatic bit writes(input logic [3:0] r, input int k);
        return ms[k].v && ms[k].w && (ms[k].d == r);
    endfunction

    function automatic bit model_raw();
        bit dep_ex;
        bit dep_ma;
        dep_ex = (id_use_src1 && writes(id_src1, 0)) || (id_two_src && writes(id_src2, 0));
        dep_ma = (id_use_src1 && writes(id_src1, 1)) || (id_two_src && writes(id_src2, 1));
        if (!id_valid) return 1'b0;
        if (forward_en) return ms[0].v && ms[0].m && dep_ex;
        return dep_ex || dep_ma;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) ms[k] = '{v: 1'b0, d: 4'd0, w: 1'b0, m: 1'b0};
        m_cnt = 0;
    endtask

    task automatic model_step();
        bit raw;
        cyc++;
        if (rst) begin
            model_clear();
        end else if (!freeze) begin
            raw = model_raw();
            if (raw && !flush) m_cnt++;
            ms[2] = ms[1];
            ms[1] = ms[0];
            if (id_valid && !raw && !flush)
                ms[0] = '{v: 1'b1, d: id_dest, w: id_wb_en, m: id_mem_read};
            else
                ms[0] = '{v: 1'b0, d: 4'd0, w: 1'b0, m: 1'b0};
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic check_model();
        int unsigned big_exp;
        int unsigned small_exp;
        big_exp   = (m_cnt > 65535) ? 65535 : m_cnt;
        small_exp = (m_cnt > 15) ? 15 : m_cnt;
        chk("hazard_stall", 32'(hazard_stall), 32'(model_raw() && !flush));
        chk("dest_ex", 32'(dest_ex), 32'(ms[0].v ? ms[0].d : 4'd0));
        chk("dest_ma", 32'(dest_ma), 32'(ms[1].v ? ms[1].d : 4'd0));
        chk("dest_wb", 32'(dest_wb), 32'(ms[2].v ? ms[2].d : 4'd0));
        chk("wb_en_ex", 32'(wb_en_ex), 32'(ms[0].v && ms[0].w));
        chk("wb_en_ma", 32'(wb_en_ma), 32'(ms[1].v && ms[1].w));
        chk("wb_en_wb", 32'(wb_en_wb), 32'(ms[2].v && ms[2].w));
        chk("mem_read_ex", 32'(mem_read_ex), 32'(ms[0].v && ms[0].m));
        chk("stall_cycles", 32'(stall_cycles), big_exp);
        chk("stall_cycles_narrow", 32'(stall_cycles_s), small_exp);
        chk("hazard_stall_narrow", 32'(hazard_stall_s), 32'(hazard_stall));
    endtask

    // Inputs are already driven; compare before the edge, then advance.
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit       rst;
        bit       v;
        bit [3:0] s1;
        bit [3:0] s2;
        bit       u1;
        bit       two;
        bit [3:0] d;
        bit       w;
        bit       mr;
        bit       fwd;
        bit       frz;
        bit       fl;
        bit       e_stall;
        bit [3:0] e_dex;
        bit       e_wex;
        bit       e_mr;
        int       e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_row(input bit r, input bit v, input int s1, input int s2, input bit u1,
                           input bit two, input int d, input bit w, input bit mr, input bit fwd,
                           input bit frz, input bit fl, input bit e_stall, input int e_dex,
                           input bit e_wex, input bit e_mr, input int e_cnt);
        vec_t t;
        t = '{rst: r, v: v, s1: 4'(s1), s2: 4'(s2), u1: u1, two: two, d: 4'(d), w: w, mr: mr,
              fwd: fwd, frz: frz, fl: fl, e_stall: e_stall, e_dex: 4'(e_dex), e_wex: e_wex,
              e_mr: e_mr, e_cnt: e_cnt};
        vecs.push_back(t);
    endtask

    task automatic apply(input vec_t t);
        rst = t.rst; id_valid = t.v; id_src1 = t.s1; id_src2 = t.s2;
        id_use_src1 = t.u1; id_two_src = t.two; id_dest = t.d; id_wb_en = t.w;
        id_mem_read = t.mr; forward_en = t.fwd; freeze = t.frz; flush = t.fl;
    endtask

    task automatic idle(input bit fwd);
        rst = 0; id_valid = 0; id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_two_src = 0;
        id_dest = 0; id_wb_en = 0; id_mem_read = 0; forward_en = fwd; freeze = 0; flush = 0;
    endtask

    initial begin
        idle(1'b0);
        rst = 1;
        model_clear();
        @(posedge clk);
        #1;

        //      rst v  s1 s2 u1 two d w mr fwd frz fl | stall dex wex mr cnt
        add_row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // No forwarding: ADD r1 ; SUB r2,r1,r4 stalls two cycles
        add_row(0, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        add_row(0, 1, 1, 4, 1, 1, 2, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1);
        add_row(0, 1, 1, 4, 1, 1, 2, 1, 0, 0, 0, 0,   1, 0, 0, 0, 2);
        add_row(0, 1, 1, 4, 1, 1, 2, 1, 0, 0, 0, 0,   0, 2, 1, 0, 2);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);
        // Forwarding: LDR r3 ; ADD r4,r3 stalls once ; ADD r5,r4 does not
        add_row(0, 1, 5, 0, 1, 0, 3, 1, 1, 1, 0, 0,   0, 3, 1, 1, 2);
        add_row(0, 1, 3, 6, 1, 1, 4, 1, 0, 1, 0, 0,   1, 0, 0, 0, 3);
        add_row(0, 1, 3, 6, 1, 1, 4, 1, 0, 1, 0, 0,   0, 4, 1, 0, 3);
        add_row(0, 1, 4, 1, 1, 1, 5, 1, 0, 1, 0, 0,   0, 5, 1, 0, 3);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 3);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 3);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 3);
        // Flush overrides a pending RAW hazard
        add_row(0, 1, 8, 0, 1, 0, 7, 1, 0, 0, 0, 0,   0, 7, 1, 0, 3);
        add_row(0, 1, 7, 0, 1, 0, 9, 1, 0, 0, 0, 1,   0, 0, 0, 0, 3);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);
        // Freeze for three cycles with a pending load-use
        add_row(0, 1, 0, 0, 1, 0, 2, 1, 1, 1, 0, 0,   0, 2, 1, 1, 3);
        add_row(0, 1, 2, 0, 1, 0, 3, 1, 0, 1, 1, 0,   1, 2, 1, 1, 3);
        add_row(0, 1, 2, 0, 1, 0, 3, 1, 0, 1, 1, 0,   1, 2, 1, 1, 3);
        add_row(0, 1, 2, 0, 1, 0, 3, 1, 0, 1, 1, 0,   1, 2, 1, 1, 3);
        add_row(0, 1, 2, 0, 1, 0, 3, 1, 0, 1, 0, 0,   1, 0, 0, 0, 4);
        add_row(0, 1, 2, 0, 1, 0, 3, 1, 0, 1, 0, 0,   0, 3, 1, 0, 4);
        // Reset mid-traffic beats freeze and flush
        add_row(1, 1, 3, 0, 1, 0, 6, 1, 0, 0, 1, 1,   0, 0, 0, 0, 0);
        add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            chk("tbl_stall", 32'(hazard_stall), 32'(vecs[i].e_stall));
            check_model();
            @(posedge clk);
            model_step();
            #1;
            chk("tbl_dest_ex", 32'(dest_ex), 32'(vecs[i].e_dex));
            chk("tbl_wb_en_ex", 32'(wb_en_ex), 32'(vecs[i].e_wex));
            chk("tbl_mem_read_ex", 32'(mem_read_ex), 32'(vecs[i].e_mr));
            chk("tbl_stall_cycles", 32'(stall_cycles), 32'(vecs[i].e_cnt));
            $display("row %0d stall=%0b dest_ex=%0d wb_en_ex=%0b mem_read_ex=%0b count=%0d",
                     i, hazard_stall, dest_ex, wb_en_ex, mem_read_ex, stall_cycles);
        end

        // Dependent chain ADD r1,r1 : two stalls per issue, far past the narrow counter's limit
        idle(1'b0);
        id_valid = 1; id_src1 = 1; id_use_src1 = 1; id_dest = 1; id_wb_en = 1;
        for (int k = 0; k < 40; k++) tick();
        chk("sat_narrow", 32'(stall_cycles_s), 32'hF);
        chk("sat_wide_count", 32'(stall_cycles), 32'(m_cnt));
        $display("saturation run: model stalls=%0d wide=%0d narrow=%0d",
                 m_cnt, stall_cycles, stall_cycles_s);

        // Random traffic over a small register window so hazards are frequent
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 63) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_src1     = 4'($urandom_range(0, 3));
            id_src2     = 4'($urandom_range(0, 3));
            id_use_src1 = ($urandom_range(0, 4) != 0);
            id_two_src  = 1'($urandom_range(0, 1));
            id_dest     = 4'($urandom_range(0, 3));
            id_wb_en    = ($urandom_range(0, 4) != 0);
            id_mem_read = ($urandom_range(0, 2) == 0);
            forward_en  = 1'($urandom_range(0, 1));
            freeze      = ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            tick();
            $display("rand %0d rst=%0b frz=%0b fl=%0b fwd=%0b stall=%0b count=%0d",
                     k, rst, freeze, flush, forward_en, hazard_stall, stall_cycles);
        end

        idle(1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
